// File: rtl/vec_mem_arbiter.sv
// Shares one memory port between a CPU and a vector coprocessor. Ties go to the vector port while its burst count is under VEC_BURST_MAX when VEC_MEM_ARB_BURST_EN is defined, and round-robin otherwise.
// Latency: a request seen in IDLE at cycle t gives mem_valid at t+1 and a requester ready at t+2+w, where w is the number of memory wait cycles.
// Backpressure: one transaction is in flight at a time. mem_* is held until mem_ready; a losing requester keeps its valid high and is picked up on a later IDLE.
module vec_mem_arbiter #(
  parameter int VEC_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_instr,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant_vec
);

  localparam logic [3:0] BURST_MAX = 4'(VEC_BURST_MAX);

  typedef enum logic [1:0] {IDLE, CPU_BUSY, VEC_BUSY, DONE} state_t;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  state_t      state_q, state_d;
  mem_req_t    req_q, req_d;
  logic        last_vec_q, last_vec_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        vec_wins;

  // Only meaningful in IDLE; a lone requester always wins.
  always_comb begin
    vec_wins = 1'b0;
    if (vec_mem_valid && !cpu_mem_valid) begin
      vec_wins = 1'b1;
    end else if (vec_mem_valid && cpu_mem_valid) begin
`ifdef VEC_MEM_ARB_BURST_EN
      vec_wins = (burst_cnt_q < BURST_MAX);
`else
      vec_wins = !last_vec_q;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    last_vec_d  = last_vec_q;
    burst_cnt_d = burst_cnt_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (!cpu_mem_valid) begin
          burst_cnt_d = 4'd0;
        end else if (vec_wins) begin
          burst_cnt_d = (burst_cnt_q < BURST_MAX) ? burst_cnt_q + 4'd1 : BURST_MAX;
        end else begin
          burst_cnt_d = 4'd0;
        end
        if (vec_wins) begin
          state_d     = VEC_BUSY;
          last_vec_d  = 1'b1;
          req_d.instr = 1'b0;
          req_d.addr  = vec_mem_addr;
          req_d.wdata = vec_mem_wdata;
          req_d.wstrb = vec_mem_wstrb;
        end else if (cpu_mem_valid) begin
          state_d     = CPU_BUSY;
          last_vec_d  = 1'b0;
          req_d.instr = cpu_mem_instr;
          req_d.addr  = cpu_mem_addr;
          req_d.wdata = cpu_mem_wdata;
          req_d.wstrb = cpu_mem_wstrb;
        end
      end
      CPU_BUSY, VEC_BUSY: begin
        if (mem_ready) begin
          state_d = DONE;
          rdata_d = mem_rdata;
        end
      end
      DONE: begin
        // No arbitration here, so a requester still holding valid in its ready cycle is not re-served.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      req_q       <= '0;
      last_vec_q  <= 1'b0;
      burst_cnt_q <= 4'd0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      last_vec_q  <= last_vec_d;
      burst_cnt_q <= burst_cnt_d;
      rdata_q     <= rdata_d;
    end
  end

  // Every output is decoded from registered state, so reset clears it immediately.
  assign mem_valid     = (state_q == CPU_BUSY) || (state_q == VEC_BUSY);
  assign grant_vec     = (state_q == VEC_BUSY);
  assign mem_instr     = req_q.instr;
  assign mem_addr      = req_q.addr;
  assign mem_wdata     = req_q.wdata;
  assign mem_wstrb     = req_q.wstrb;
  assign cpu_mem_ready = (state_q == DONE) && !last_vec_q;
  assign vec_mem_ready = (state_q == DONE) && last_vec_q;
  assign cpu_mem_rdata = rdata_q;
  assign vec_mem_rdata = rdata_q;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Directed bench for vec_mem_arbiter: table of single transactions, then continuous tie and reset-mid-operation sequences.
module tb_vec_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        cpu_mem_valid, cpu_mem_instr;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_ready;
  logic [31:0] cpu_mem_rdata;
  logic        vec_mem_valid;
  logic [31:0] vec_mem_addr, vec_mem_wdata;
  logic [3:0]  vec_mem_wstrb;
  logic        vec_mem_ready;
  logic [31:0] vec_mem_rdata;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        grant_vec;

  int n_chk;
  int n_fail;

  vec_mem_arbiter #(.VEC_BURST_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready),
    .cpu_mem_rdata(cpu_mem_rdata),
    .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr),
    .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb),
    .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_vec(grant_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cpu_v;
    logic        cpu_instr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        vec_v;
    logic [31:0] vec_addr;
    logic [31:0] vec_wdata;
    logic [3:0]  vec_wstrb;
    int          w;
    logic [31:0] rdata;
    logic        exp_vec;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic run_txn(input vec_t r, input int idx);
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_instr;
    e_instr = r.exp_vec ? 1'b0 : r.cpu_instr;
    e_addr  = r.exp_vec ? r.vec_addr : r.cpu_addr;
    e_wdata = r.exp_vec ? r.vec_wdata : r.cpu_wdata;
    e_wstrb = r.exp_vec ? r.vec_wstrb : r.cpu_wstrb;
    cpu_mem_valid = r.cpu_v;
    cpu_mem_instr = r.cpu_instr;
    cpu_mem_addr  = r.cpu_addr;
    cpu_mem_wdata = r.cpu_wdata;
    cpu_mem_wstrb = r.cpu_wstrb;
    vec_mem_valid = r.vec_v;
    vec_mem_addr  = r.vec_addr;
    vec_mem_wdata = r.vec_wdata;
    vec_mem_wstrb = r.vec_wstrb;
    chk($sformatf("t%0d_idle_valid", idx), 32'(mem_valid), 32'd0);
    step();
    chk($sformatf("t%0d_valid", idx), 32'(mem_valid), 32'd1);
    chk($sformatf("t%0d_grant_vec", idx), 32'(grant_vec), 32'(r.exp_vec));
    chk($sformatf("t%0d_instr", idx), 32'(mem_instr), 32'(e_instr));
    chk($sformatf("t%0d_addr", idx), mem_addr, e_addr);
    chk($sformatf("t%0d_wdata", idx), mem_wdata, e_wdata);
    chk($sformatf("t%0d_wstrb", idx), 32'(mem_wstrb), 32'(e_wstrb));
    for (int k = 1; k <= r.w; k++) begin
      step();
      chk($sformatf("t%0d_hold_valid%0d", idx, k), 32'(mem_valid), 32'd1);
      chk($sformatf("t%0d_hold_addr%0d", idx, k), mem_addr, e_addr);
      chk($sformatf("t%0d_hold_wdata%0d", idx, k), mem_wdata, e_wdata);
      chk($sformatf("t%0d_hold_wstrb%0d", idx, k), 32'(mem_wstrb), 32'(e_wstrb));
      chk($sformatf("t%0d_early_ready%0d", idx, k), 32'(cpu_mem_ready | vec_mem_ready), 32'd0);
      if (k == r.w) begin
        mem_ready = 1'b1;
        mem_rdata = r.rdata;
      end
    end
    step();
    mem_ready = 1'b0;
    mem_rdata = ~r.rdata;
    chk($sformatf("t%0d_cpu_ready", idx), 32'(cpu_mem_ready), 32'(!r.exp_vec));
    chk($sformatf("t%0d_vec_ready", idx), 32'(vec_mem_ready), 32'(r.exp_vec));
    chk($sformatf("t%0d_cpu_rdata", idx), cpu_mem_rdata, r.rdata);
    chk($sformatf("t%0d_vec_rdata", idx), vec_mem_rdata, r.rdata);
    chk($sformatf("t%0d_done_valid", idx), 32'(mem_valid), 32'd0);
    chk($sformatf("t%0d_done_grant", idx), 32'(grant_vec), 32'd0);
    cpu_mem_valid = 1'b0;
    vec_mem_valid = 1'b0;
    step();
    chk($sformatf("t%0d_ready_once", idx), 32'(cpu_mem_ready | vec_mem_ready), 32'd0);
    chk($sformatf("t%0d_back_idle", idx), 32'(mem_valid), 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int ng;
    logic exp_g;
    n_chk  = 0;
    n_fail = 0;

    //         cpu_v instr addr          wdata         wstrb    vec_v addr          wdata         wstrb    w  rdata         exp_vec
    tbl[0] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0,        4'h0,    1'b0, 32'h0,        32'h0,        4'h0,    1, 32'h0040_0113, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0,    1'b1, 32'h0000_0190, 32'h0403_0201, 4'b0001, 1, 32'h1111_2222, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'hdead_beef, 4'b1111, 1'b0, 32'h0,        32'h0,        4'h0,    5, 32'h5555_aaaa, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0,    1'b1, 32'h0000_0300, 32'h0,        4'h0,    2, 32'h1234_5678, 1'b1};
`ifdef VEC_MEM_ARB_BURST_EN
    tbl[4] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0,        4'h0,    1'b1, 32'h0000_0044, 32'h7777_8888, 4'b1100, 1, 32'hcafe_f00d, 1'b1};
`else
    tbl[4] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0,        4'h0,    1'b1, 32'h0000_0044, 32'h7777_8888, 4'b1100, 1, 32'hcafe_f00d, 1'b0};
`endif
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0080, 32'h9999_0000, 4'b0011, 1'b0, 32'h0,        32'h0,        4'h0,    2, 32'h0bad_f00d, 1'b0};

    resetn = 1'b1;
    cpu_mem_valid = 1'b0; cpu_mem_instr = 1'b0; cpu_mem_addr = '0;
    cpu_mem_wdata = '0;   cpu_mem_wstrb = '0;
    vec_mem_valid = 1'b0; vec_mem_addr = '0; vec_mem_wdata = '0; vec_mem_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_cpu_ready", 32'(cpu_mem_ready), 32'd0);
    chk("rst_vec_ready", 32'(vec_mem_ready), 32'd0);
    chk("rst_grant_vec", 32'(grant_vec), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_instr", 32'(mem_instr), 32'd0);
    chk("rst_cpu_rdata", cpu_mem_rdata, 32'd0);
    chk("rst_vec_rdata", vec_mem_rdata, 32'd0);
    step();
    step();
    resetn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_txn(tbl[i], i);

    // Continuous tie starting from reset: last winner CPU, burst count zero.
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    cpu_mem_valid = 1'b1; cpu_mem_instr = 1'b0; cpu_mem_addr = 32'h0000_0a00;
    vec_mem_valid = 1'b1; vec_mem_addr = 32'h0000_0b00;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 10; cyc++) begin
      step();
      if (mem_valid) begin
`ifdef VEC_MEM_ARB_BURST_EN
        exp_g = ((ng % 5) != 4);
`else
        exp_g = ((ng % 2) == 0);
`endif
        chk($sformatf("tie_grant%0d", ng), 32'(grant_vec), 32'(exp_g));
        ng++;
      end
    end
    chk("tie_grant_count", 32'(ng), 32'd10);
    cpu_mem_valid = 1'b0;
    vec_mem_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    mem_ready = 1'b0;
    step();
    chk("tie_drained", 32'(mem_valid), 32'd0);

    // Reset while the vector transaction is waiting on memory.
    vec_mem_valid = 1'b1; vec_mem_addr = 32'h0000_0500;
    vec_mem_wdata = 32'h0102_0304; vec_mem_wstrb = 4'b1111;
    step();
    chk("mid_valid", 32'(mem_valid), 32'd1);
    chk("mid_grant_vec", 32'(grant_vec), 32'd1);
    vec_mem_valid = 1'b0;
    step();
    chk("mid_withdrawn_still_busy", 32'(mem_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_grant", 32'(grant_vec), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'hffff_0000;
    step();
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mid_no_vec_ready%0d", k), 32'(vec_mem_ready), 32'd0);
      chk($sformatf("mid_no_cpu_ready%0d", k), 32'(cpu_mem_ready), 32'd0);
      chk($sformatf("mid_idle%0d", k), 32'(mem_valid), 32'd0);
    end
    mem_ready = 1'b0;
    step();
    run_txn(tbl[0], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
